// File: rtl/uart_system_sequencer.sv
// uart_system_sequencer: top-level run sequencer for the UART memory loader and the cores.
// Once armed it runs four phases in order: UART load of IMEM, UART load of DMEM, a core run
// with the cores owning memory, then a UART dump of the DMEM result window.
//
// Optional feature macro: PROC_TIMEOUT_EN. When defined, a bounded core run sets the sticky
// error flag and forces the result dump. When undefined, the core run waits for proc_done
// indefinitely and error is tied 0.
//
// Ports:
//   clk               system clock
//   rstN              asynchronous active-low reset
//   start_n           arm request, active low, already synchronised (falling edge arms)
//   mem_received      pulse: UART receive of the current range done
//   mem_transmitted   pulse: UART transmit of the current range done
//   uart_txStart_n    active-low 1-cycle transmit request
//   toggle_addr_range constant 1 (explicit address ranges)
//   tx_start_addr     first transmit address (RESULT_START)
//   tx_end_addr       last transmit address (RESULT_END)
//   rx_end_addr       last receive address for the current load phase
//   uart_mem_sel      UART-side target: 0 = IMEM, 1 = DMEM
//   mem_owner         memory owner: 0 = UART interface, 1 = cores
//   proc_start        1-cycle start pulse to the cores
//   proc_done         cores finished (level or pulse)
//   seq_state         current state code
//   error             sticky processor-timeout flag
module uart_system_sequencer #(
  parameter int unsigned MEM_ADDR_LENGTH = 12,
  parameter int unsigned IMEM_END_ADDR   = 255,
  parameter int unsigned DMEM_END_ADDR   = 4095,
  parameter int unsigned RESULT_START    = 0,
  parameter int unsigned RESULT_END      = 63,
  parameter int unsigned TIMEOUT_CYCLES  = 2**20,
  parameter int unsigned TIMEOUT_WIDTH   = 24
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       start_n,
  input  logic                       mem_received,
  input  logic                       mem_transmitted,
  output logic                       uart_txStart_n,
  output logic                       toggle_addr_range,
  output logic [MEM_ADDR_LENGTH-1:0] tx_start_addr,
  output logic [MEM_ADDR_LENGTH-1:0] tx_end_addr,
  output logic [MEM_ADDR_LENGTH-1:0] rx_end_addr,
  output logic                       uart_mem_sel,
  output logic                       mem_owner,
  output logic                       proc_start,
  input  logic                       proc_done,
  output logic [2:0]                 seq_state,
  output logic                       error
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoadImem = 3'd1,
    StLoadDmem = 3'd2,
    StRunStart = 3'd3,
    StRunWait  = 3'd4,
    StTxStart  = 3'd5,
    StTxWait   = 3'd6,
    StDone     = 3'd7
  } state_e;

  state_e state_q, state_d;
  logic   start_n_q;
  logic   arm;
  logic   timeout_hit;
  logic   proc_start_q;
  logic   tx_start_n_q;
  logic   mem_owner_q;
  logic   error_q, error_d;

  // Arm only on a 1->0 transition so a held-low start_n arms exactly once.
  assign arm = start_n_q & ~start_n;

`ifdef PROC_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_hit = (state_q == StRunWait) &&
                       (tmo_cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StRunStart) begin
      tmo_cnt_d = '0;
    end else if (state_q == StRunWait) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // proc_done wins over a same-cycle expiry.
  always_comb begin
    error_d = error_q;
    if (timeout_hit && !proc_done) begin
      error_d = 1'b1;
    end else if (state_q == StDone && arm) begin
      error_d = 1'b0;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES ^ TIMEOUT_WIDTH;
  assign timeout_hit        = 1'b0;
  assign error_d            = 1'b0;
`endif

  // State register; pulses and ownership are registered from the next state so they are
  // glitch-free and aligned with the cycle the FSM occupies the state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StIdle;
      start_n_q    <= 1'b1;
      proc_start_q <= 1'b0;
      tx_start_n_q <= 1'b1;
      mem_owner_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_n_q    <= start_n;
      proc_start_q <= (state_d == StRunStart);
      tx_start_n_q <= (state_d != StTxStart);
      mem_owner_q  <= (state_d == StRunStart) || (state_d == StRunWait);
      error_q      <= error_d;
    end
  end

  // Next-state logic; events outside their owning state are simply ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (arm) state_d = StLoadImem;
      StLoadImem: if (mem_received) state_d = StLoadDmem;
      StLoadDmem: if (mem_received) state_d = StRunStart;
      StRunStart: state_d = StRunWait;
      StRunWait:  if (proc_done || timeout_hit) state_d = StTxStart;
      StTxStart:  state_d = StTxWait;
      StTxWait:   if (mem_transmitted) state_d = StDone;
      StDone:     if (arm) state_d = StLoadImem;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    uart_mem_sel = (state_q == StLoadDmem) || (state_q == StTxStart) || (state_q == StTxWait);
    rx_end_addr  = (state_q == StLoadDmem) ? MEM_ADDR_LENGTH'(DMEM_END_ADDR)
                                           : MEM_ADDR_LENGTH'(IMEM_END_ADDR);
  end

  assign toggle_addr_range = 1'b1;
  assign tx_start_addr     = MEM_ADDR_LENGTH'(RESULT_START);
  assign tx_end_addr       = MEM_ADDR_LENGTH'(RESULT_END);
  assign proc_start        = proc_start_q;
  assign uart_txStart_n    = tx_start_n_q;
  assign mem_owner         = mem_owner_q;
  assign error             = error_q;
  assign seq_state         = state_q;

endmodule

// File: tb/tb_uart_system_sequencer.sv
module tb_uart_system_sequencer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start_n;
  logic        mem_received;
  logic        mem_transmitted;
  logic        proc_done;
  logic        uart_txStart_n;
  logic        toggle_addr_range;
  logic [11:0] tx_start_addr;
  logic [11:0] tx_end_addr;
  logic [11:0] rx_end_addr;
  logic        uart_mem_sel;
  logic        mem_owner;
  logic        proc_start;
  logic [2:0]  seq_state;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int ps_cnt   = 0;
  int tx_cnt   = 0;
  int b2b_cnt  = 0;
  logic prev_ps = 1'b0;
  logic prev_tx = 1'b0;

  always #5 clk = ~clk;

  uart_system_sequencer #(
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_WIDTH (24)
  ) dut (
    .clk              (clk),
    .rstN             (rstN),
    .start_n          (start_n),
    .mem_received     (mem_received),
    .mem_transmitted  (mem_transmitted),
    .uart_txStart_n   (uart_txStart_n),
    .toggle_addr_range(toggle_addr_range),
    .tx_start_addr    (tx_start_addr),
    .tx_end_addr      (tx_end_addr),
    .rx_end_addr      (rx_end_addr),
    .uart_mem_sel     (uart_mem_sel),
    .mem_owner        (mem_owner),
    .proc_start       (proc_start),
    .proc_done        (proc_done),
    .seq_state        (seq_state),
    .error            (error)
  );

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rstN) begin
      if (proc_start) ps_cnt++;
      if (!uart_txStart_n) tx_cnt++;
      if ((proc_start && prev_ps) || (!uart_txStart_n && prev_tx)) b2b_cnt++;
      prev_ps = proc_start;
      prev_tx = !uart_txStart_n;
    end else begin
      prev_ps = 1'b0;
      prev_tx = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx();
    mem_received = 1'b1;
    step();
    mem_received = 1'b0;
  endtask

  task automatic pulse_tx_done();
    mem_transmitted = 1'b1;
    step();
    mem_transmitted = 1'b0;
  endtask

  task automatic clear_counts();
    ps_cnt  = 0;
    tx_cnt  = 0;
    b2b_cnt = 0;
  endtask

  initial begin
    rstN            = 1'b0;
    start_n         = 1'b1;
    mem_received    = 1'b0;
    mem_transmitted = 1'b0;
    proc_done       = 1'b0;
    step();
    step();
    check_eq("rst_state", seq_state, 0);
    check_eq("rst_txstart_n", uart_txStart_n, 1);
    check_eq("rst_proc_start", proc_start, 0);
    check_eq("rst_mem_owner", mem_owner, 0);
    check_eq("rst_mem_sel", uart_mem_sel, 0);
    check_eq("rst_error", error, 0);
    check_eq("toggle_range", toggle_addr_range, 1);
    check_eq("tx_start_addr", tx_start_addr, 0);
    check_eq("tx_end_addr", tx_end_addr, 63);
    check_eq("rst_rx_end", rx_end_addr, 255);
    rstN = 1'b1;
    step();
    step();
    check_eq("idle_no_arm", seq_state, 0);

    // Arm and full run.
    clear_counts();
    start_n = 1'b0;
    step();
    check_eq("arm_state", seq_state, 1);
    check_eq("imem_rx_end", rx_end_addr, 255);
    check_eq("imem_sel", uart_mem_sel, 0);
    check_eq("imem_proc_start", proc_start, 0);
    check_eq("imem_txstart_n", uart_txStart_n, 1);

    // Spurious events in LOAD_IMEM.
    mem_transmitted = 1'b1;
    proc_done       = 1'b1;
    step();
    step();
    mem_transmitted = 1'b0;
    proc_done       = 1'b0;
    step();
    check_eq("spurious_state", seq_state, 1);
    check_eq("spurious_ps", ps_cnt, 0);
    check_eq("spurious_tx", tx_cnt, 0);

    pulse_rx();
    check_eq("dmem_state", seq_state, 2);
    check_eq("dmem_sel", uart_mem_sel, 1);
    check_eq("dmem_rx_end", rx_end_addr, 4095);
    check_eq("dmem_owner", mem_owner, 0);
    pulse_rx();
    check_eq("runstart_state", seq_state, 3);
    check_eq("runstart_pulse", proc_start, 1);
    check_eq("runstart_owner", mem_owner, 1);
    step();
    check_eq("runwait_state", seq_state, 4);
    check_eq("runwait_pulse", proc_start, 0);
    check_eq("runwait_owner", mem_owner, 1);
    check_eq("runwait_rx_end", rx_end_addr, 255);
    repeat (99) step();
    check_eq("runwait_hold", seq_state, 4);
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
    check_eq("txstart_state", seq_state, 5);
    check_eq("txstart_pulse", uart_txStart_n, 0);
    check_eq("txstart_owner", mem_owner, 0);
    check_eq("txstart_sel", uart_mem_sel, 1);
    step();
    check_eq("txwait_state", seq_state, 6);
    check_eq("txwait_pulse", uart_txStart_n, 1);
    check_eq("txwait_sel", uart_mem_sel, 1);
    pulse_tx_done();
    check_eq("done_state", seq_state, 7);
    check_eq("done_error", error, 0);
    step();
    check_eq("run_ps_count", ps_cnt, 1);
    check_eq("run_tx_count", tx_cnt, 1);
    check_eq("run_b2b", b2b_cnt, 0);

    // start_n held low through DONE: no re-arm until released and pressed again.
    repeat (3) step();
    check_eq("held_no_rearm", seq_state, 7);
    start_n = 1'b1;
    step();
    step();
    check_eq("release_no_arm", seq_state, 7);
    start_n = 1'b0;
    step();
    check_eq("rearm_state", seq_state, 1);

    // Async reset during RUN_WAIT.
    pulse_rx();
    pulse_rx();
    step();
    check_eq("pre_rst_state", seq_state, 4);
    check_eq("pre_rst_owner", mem_owner, 1);
    rstN    = 1'b0;
    start_n = 1'b1;
    #1;
    check_eq("async_rst_owner", mem_owner, 0);
    check_eq("async_rst_state", seq_state, 0);
    step();
    rstN = 1'b1;
    step();
    check_eq("post_rst_idle", seq_state, 0);

    // Clean rerun with proc_done already high on entry to RUN_WAIT.
    clear_counts();
    start_n = 1'b0;
    step();
    check_eq("rerun_arm", seq_state, 1);
    pulse_rx();
    pulse_rx();
    check_eq("rerun_runstart", seq_state, 3);
    proc_done = 1'b1;
    step();
    check_eq("early_done_wait", seq_state, 4);
    step();
    proc_done = 1'b0;
    check_eq("early_done_exit", seq_state, 5);
    check_eq("early_done_txpulse", uart_txStart_n, 0);
    step();
    pulse_tx_done();
    check_eq("rerun_done", seq_state, 7);
    step();
    check_eq("rerun_ps_count", ps_cnt, 1);
    check_eq("rerun_tx_count", tx_cnt, 1);

`ifdef PROC_TIMEOUT_EN
    begin
      int n_wait;
      start_n = 1'b1;
      step();
      start_n = 1'b0;
      step();
      pulse_rx();
      pulse_rx();
      step();
      n_wait = 0;
      while (seq_state == 3'd4 && n_wait < 100) begin
        n_wait++;
        step();
      end
      check_eq("tmo_wait_cycles", n_wait, 16);
      check_eq("tmo_state", seq_state, 5);
      check_eq("tmo_error", error, 1);
      check_eq("tmo_txpulse", uart_txStart_n, 0);
      step();
      pulse_tx_done();
      check_eq("tmo_done_error", error, 1);
      start_n = 1'b1;
      step();
      start_n = 1'b0;
      step();
      check_eq("tmo_rearm_state", seq_state, 1);
      check_eq("tmo_error_clear", error, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
